// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from the TX FIFO and serialises each
// one as start / 8 data (LSB first) / optional parity / 1-2 stop bits.
// The line output is registered, so it changes only on state or bit-slot edges.
module uart_tx_ctrl #(
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;

  logic start_ok;
  logic baud_end;

  // tx_en / fifo_empty only matter where they are sampled (IDLE, end of STOP)
  assign start_ok = tx_en & ~fifo_empty;
  assign baud_end = (baud_cnt == CW'(BAUD_DIV - 1));

  // Frame sequencer; every output is registered and set on the edge that
  // enters the state or bit slot it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (start_ok) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        POP: begin
          // FIFO data becomes valid in the following cycle
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_data;
          par_bit   <= (^fifo_data) ^ 1'(PARITY_ODD);
          state     <= START;
          tx        <= 1'b0;
          baud_cnt  <= '0;
        end
        START: begin
          if (baud_end) begin
            state    <= DATA;
            tx       <= shift_reg[0];
            bit_idx  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              stop_cnt <= 1'b0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              // next bit is shift_reg[1], which becomes shift_reg[0] after the shift
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_done <= 1'b1;
              if (start_ok) begin
                // back-to-back frame: skip IDLE
                state      <= POP;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
